// File: rtl/mips_pkg.sv
// Shared MIPS core definitions: reset vector, instruction field slices and the fetch pair type.
`default_nettype none

package mips_pkg;

  localparam logic [31:0] RESET_PC = 32'h0000_3000;

  localparam int OP_HI = 31;
  localparam int OP_LO = 26;
  localparam int RS_HI = 25;
  localparam int RS_LO = 21;
  localparam int RT_HI = 20;
  localparam int RT_LO = 16;
  localparam int RD_HI = 15;
  localparam int RD_LO = 11;
  localparam int SH_HI = 10;
  localparam int SH_LO = 6;
  localparam int FN_HI = 5;
  localparam int FN_LO = 0;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_pair_t;

endpackage

`default_nettype wire

// File: rtl/instr_fields.sv
// Combinational splitter of a 32-bit MIPS instruction word into its encoding fields.
`default_nettype none

module instr_fields
  import mips_pkg::*;
(
  input  logic [31:0] instr,
  output logic [5:0]  special,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  rd,
  output logic [4:0]  shamt,
  output logic [5:0]  funct,
  output logic [15:0] imm16,
  output logic [25:0] imm26
);

  assign special = instr[OP_HI:OP_LO];
  assign rs      = instr[RS_HI:RS_LO];
  assign rt      = instr[RT_HI:RT_LO];
  assign rd      = instr[RD_HI:RD_LO];
  assign shamt   = instr[SH_HI:SH_LO];
  assign funct   = instr[FN_HI:FN_LO];
  assign imm16   = instr[RD_HI:FN_LO];
  assign imm26   = instr[RS_HI:FN_LO];

endmodule

`default_nettype wire

// File: rtl/if_id_queue.sv
// Fetch-to-decode instruction queue with flush on redirect; head word presented pre-split.
`default_nettype none

module if_id_queue
  import mips_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PTR_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [31:0]      in_pc,
  input  logic [31:0]      in_instr,
  output logic             in_ready,
  input  logic             flush,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [31:0]      out_pc,
  output logic [31:0]      out_npc,
  output logic [5:0]       out_special,
  output logic [4:0]       out_rs,
  output logic [4:0]       out_rt,
  output logic [4:0]       out_rd,
  output logic [4:0]       out_shamt,
  output logic [5:0]       out_funct,
  output logic [15:0]      out_imm16,
  output logic [25:0]      out_imm26,
  output logic [PTR_W-1:0] count
);

  localparam int IDX_W = PTR_W - 1;

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  fetch_pair_t      mem [DEPTH];
  fetch_pair_t      head;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;

  // Wrap bit differs with equal index bits only when the writer is a full lap ahead.
  assign full  = (wr_ptr[PTR_W-1] != rd_ptr[PTR_W-1]) &&
                 (wr_ptr[IDX_W-1:0] == rd_ptr[IDX_W-1:0]);
  assign empty = (wr_ptr == rd_ptr);

  assign in_ready  = !full;
  assign out_valid = !empty;
  assign push      = in_valid && in_ready && !flush;
  assign pop       = out_valid && out_ready && !flush;
  assign count     = wr_ptr - rd_ptr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[IDX_W-1:0]] <= '{pc: in_pc, instr: in_instr};
  end

  // An empty queue presents an all-zero word so decode sees a NOP.
  assign head    = empty ? '0 : mem[rd_ptr[IDX_W-1:0]];
  assign out_pc  = head.pc;
  assign out_npc = empty ? 32'd0 : head.pc + 32'd4;

  instr_fields u_fields (
    .instr   (head.instr),
    .special (out_special),
    .rs      (out_rs),
    .rt      (out_rt),
    .rd      (out_rd),
    .shamt   (out_shamt),
    .funct   (out_funct),
    .imm16   (out_imm16),
    .imm26   (out_imm26)
  );

endmodule

`default_nettype wire
